// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time, read-modify-write for sb/sh,
// sign/zero extension for sub-word loads, fault detection at acceptance.
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_write_en,
   output logic [31:0] mem_read_addr,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MERGE = 3'd2,
      STORE = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] addr_r;
   logic [2:0]  funct3_r;
   logic [31:0] wdata_r;
   logic [31:0] merged_r;
   logic        fault_s;
   logic [31:0] word_addr_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic [31:0] load_data_s;
   logic [31:0] merge_data_s;

   assign word_addr_s = {addr_r[31:2], 2'b00};

   // Classify the incoming request as faulting from its funct3, alignment and range
   always_comb begin
      fault_s = 1'b0;
      case (req_funct3)
         3'd0, 3'd4: fault_s = 1'b0;
         3'd1, 3'd5: fault_s = req_addr[0];
         3'd2:       fault_s = (req_addr[1:0] != 2'b00);
         default:    fault_s = 1'b1;
      endcase
      fault_s = fault_s | (req_we & (req_funct3 > 3'd2)) | (req_addr >= ADDR_LIMIT);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!req_valid) begin
               state_next_s = IDLE;
            end else if (fault_s) begin
               state_next_s = FAULT;
            end else if (!req_we) begin
               state_next_s = LOAD;
            end else if (req_funct3 == 3'd2) begin
               state_next_s = STORE;
            end else begin
               state_next_s = MERGE;
            end
         end
         LOAD:    state_next_s = IDLE;
         MERGE:   state_next_s = STORE;
         STORE:   state_next_s = IDLE;
         FAULT:   state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Lane selection and extension of the word returned by memory
   always_comb begin
      case (addr_r[1:0])
         2'd0:    byte_s = mem_read_data[7:0];
         2'd1:    byte_s = mem_read_data[15:8];
         2'd2:    byte_s = mem_read_data[23:16];
         2'd3:    byte_s = mem_read_data[31:24];
         default: byte_s = 8'd0;
      endcase
      if (addr_r[1]) begin
         half_s = mem_read_data[31:16];
      end else begin
         half_s = mem_read_data[15:0];
      end
      case (funct3_r)
         3'd0:    load_data_s = {{24{byte_s[7]}}, byte_s};
         3'd1:    load_data_s = {{16{half_s[15]}}, half_s};
         3'd4:    load_data_s = {24'd0, byte_s};
         3'd5:    load_data_s = {16'd0, half_s};
         default: load_data_s = mem_read_data;
      endcase
   end

   // Old word with the addressed byte or halfword lane replaced by store data
   always_comb begin
      merge_data_s = mem_read_data;
      if (funct3_r == 3'd0) begin
         case (addr_r[1:0])
            2'd0:    merge_data_s[7:0]   = wdata_r[7:0];
            2'd1:    merge_data_s[15:8]  = wdata_r[7:0];
            2'd2:    merge_data_s[23:16] = wdata_r[7:0];
            2'd3:    merge_data_s[31:24] = wdata_r[7:0];
            default: merge_data_s = mem_read_data;
         endcase
      end else if (addr_r[1]) begin
         merge_data_s[31:16] = wdata_r[15:0];
      end else begin
         merge_data_s[15:0] = wdata_r[15:0];
      end
   end

   // Request capture, merged word and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r     <= 32'd0;
         funct3_r   <= 3'd0;
         wdata_r    <= 32'd0;
         merged_r   <= 32'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_fault <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  addr_r   <= req_addr;
                  funct3_r <= req_funct3;
                  wdata_r  <= req_wdata;
               end
            end
            LOAD: begin
               resp_valid <= 1'b1;
               resp_rdata <= load_data_s;
               resp_fault <= 1'b0;
            end
            MERGE: merged_r <= merge_data_s;
            STORE: begin
               resp_valid <= 1'b1;
               resp_rdata <= 32'd0;
               resp_fault <= 1'b0;
            end
            FAULT: begin
               resp_valid <= 1'b1;
               resp_rdata <= 32'd0;
               resp_fault <= 1'b1;
            end
            default: resp_valid <= 1'b0;
         endcase
      end
   end

   // Handshake and memory port decode; write enable comes straight from state
   always_comb begin
      req_ready      = 1'b0;
      mem_write_en   = 1'b0;
      mem_read_addr  = 32'd0;
      mem_write_addr = 32'd0;
      mem_write_data = 32'd0;
      case (state_r)
         IDLE:        req_ready = 1'b1;
         LOAD, MERGE: mem_read_addr = word_addr_s;
         STORE: begin
            mem_write_en   = 1'b1;
            mem_write_addr = word_addr_s;
            if (funct3_r == 3'd2) begin
               mem_write_data = wdata_r;
            end else begin
               mem_write_data = merged_r;
            end
         end
         default: req_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a byte-addressed reference memory model.
module tb_load_store_unit;
   localparam int MEM_WORDS = 32;
   localparam int MEM_BYTES = 4 * MEM_WORDS;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_write_en;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:MEM_WORDS-1];
   logic [7:0]  ref_bytes [0:MEM_BYTES-1];
   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_count = 0;
   int          resp_count = 0;
   logic [31:0] last_wr_addr = 32'd0;
   logic [31:0] last_wr_data = 32'd0;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_write_en(mem_write_en), .mem_read_addr(mem_read_addr),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_read_addr[6:2]];

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_write_addr[6:2]] = mem_write_data;
         last_wr_addr = mem_write_addr;
         last_wr_data = mem_write_data;
         wr_count++;
      end
   end

   always @(negedge clk) begin
      if (resp_valid) resp_count++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (byte-addressed, little-endian) ----------------
   function automatic logic [31:0] ref_word(input int i);
      return {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && f3 > 3'd2) return 1'b1;
      if (a >= 32'(MEM_BYTES)) return 1'b1;
      if (a % size_of(f3) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = size_of(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = size_of(f3);
      for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = d[8*i +: 8];
   endtask

   task automatic set_word(input int i, input logic [31:0] v);
      mem[i] = v;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = v[8*b +: 8];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one request and observe its response; returns at 1 time unit after the response edge
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata, output logic fault,
                         output int lat, output int busy, output logic timeout);
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      busy = req_ready ? 0 : 1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (!resp_valid && !req_ready) busy++;
      end while (!resp_valid && lat < 10);
      timeout = !resp_valid;
      rdata = resp_rdata;
      fault = resp_fault;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      for (int i = 0; i < MEM_WORDS; i++) set_word(i, $urandom);
      idle(2);
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (resp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
      n_cmp++; if (resp_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", resp_fault); end
      n_cmp++; if (mem_write_en !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", mem_write_en); end
      n_cmp++;
      if ({mem_read_addr, mem_write_addr, mem_write_data} !== 96'd0) begin
         n_err++;
         $display("FAIL reset_idle_ports: got %h %h %h want 0 0 0", mem_read_addr, mem_write_addr, mem_write_data);
      end
      reset = 1'b0;
      idle(2);
      n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got ready %b valid %b want 1 0", req_ready, resp_valid); end
   endtask

   task automatic test_sub_store();
      logic [31:0] rd; logic ft; int lat, busy, wc; logic to;
      set_word(1, 32'h1122_3344);
      wc = wr_count;
      do_req(1'b1, 3'd0, 32'h5, 32'h0000_00AB, rd, ft, lat, busy, to);
      ref_store(3'd0, 32'h5, 32'h0000_00AB);
      n_cmp++; if (to || lat != 2) begin n_err++; $display("FAIL sb_latency: got %0d want 2", lat); end
      n_cmp++; if (busy != 2) begin n_err++; $display("FAIL sb_ready_low: got %0d cycles want 2", busy); end
      n_cmp++; if (ft !== 1'b0 || rd !== 32'd0) begin n_err++; $display("FAIL sb_resp: got fault %b rdata %h want 0 0", ft, rd); end
      n_cmp++; if (wr_count != wc + 1) begin n_err++; $display("FAIL sb_write_count: got %0d want %0d", wr_count - wc, 1); end
      n_cmp++; if (last_wr_addr !== 32'h4 || last_wr_data !== 32'h1122_AB44) begin n_err++; $display("FAIL sb_write: got %h=%h want 00000004=1122ab44", last_wr_addr, last_wr_data); end
      idle(1);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL sb_pulse_width: got %b want 0", resp_valid); end
      do_req(1'b1, 3'd1, 32'h6, 32'hFACE_5566, rd, ft, lat, busy, to);
      ref_store(3'd1, 32'h6, 32'hFACE_5566);
      n_cmp++; if (to || lat != 2) begin n_err++; $display("FAIL sh_latency: got %0d want 2", lat); end
      n_cmp++; if (mem[1] !== ref_word(1)) begin n_err++; $display("FAIL sh_word: got %h want %h", mem[1], ref_word(1)); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] ads [5]  = '{32'h8, 32'h8, 32'hA, 32'hA, 32'h8};
      logic [31:0] exps [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_F0FF};
      logic [31:0] rd; logic ft; int lat, busy; logic to;
      set_word(2, 32'h8000_F0FF);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3s[i], ads[i], $urandom, rd, ft, lat, busy, to);
         n_cmp++; if (to || rd !== exps[i] || ft !== 1'b0) begin n_err++; $display("FAIL load_%0d: got %h fault %b want %h 0", i, rd, ft, exps[i]); end
         n_cmp++; if (lat != 1) begin n_err++; $display("FAIL load_latency_%0d: got %0d want 1", i, lat); end
      end
      idle(3);
      n_cmp++; if (resp_rdata !== 32'h8000_F0FF) begin n_err++; $display("FAIL rdata_hold: got %h want 8000f0ff", resp_rdata); end
   endtask

   task automatic test_faults();
      logic        wes [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  f3s [7] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd7};
      logic [31:0] ads [7] = '{32'h6, 32'h3, 32'h0, 32'h80, 32'h0, 32'h1, 32'h4};
      logic [31:0] rd; logic ft; int lat, busy, wc; logic to;
      wc = wr_count;
      for (int i = 0; i < 7; i++) begin
         do_req(wes[i], f3s[i], ads[i], $urandom, rd, ft, lat, busy, to);
         n_cmp++; if (to || ft !== 1'b1 || rd !== 32'd0 || lat != 1) begin n_err++; $display("FAIL fault_%0d: got fault %b rdata %h lat %0d want 1 0 1", i, ft, rd, lat); end
         do_req(1'b0, 3'd2, 32'h8, 32'd0, rd, ft, lat, busy, to);
      end
      n_cmp++; if (wr_count != wc) begin n_err++; $display("FAIL fault_no_write: got %0d writes want 0", wr_count - wc); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic ft; int lat, busy; logic to; time t0;
      do_req(1'b1, 3'd2, 32'h0, 32'hDEAD_BEEF, rd, ft, lat, busy, to);
      ref_store(3'd2, 32'h0, 32'hDEAD_BEEF);
      t0 = $time;
      n_cmp++; if (to || lat != 1 || req_ready !== 1'b1) begin n_err++; $display("FAIL sw_resp: got lat %0d ready %b want 1 1", lat, req_ready); end
      do_req(1'b0, 3'd2, 32'h0, 32'd0, rd, ft, lat, busy, to);
      n_cmp++; if (to || rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_data: got %h want deadbeef", rd); end
      n_cmp++; if ($time - t0 != 20) begin n_err++; $display("FAIL b2b_timing: got %0t want 20", $time - t0); end
   endtask

   task automatic test_reset_mid();
      int wc, rc;
      idle(2);
      wc = wr_count; rc = resp_count;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h2; req_wdata = 32'h1234;
      idle(1);
      req_valid = 1'b0;
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL merge_busy: got ready %b want 0", req_ready); end
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(3);
      n_cmp++; if (wr_count != wc || mem[0] !== ref_word(0)) begin n_err++; $display("FAIL reset_merge_mem: got %h writes %0d want %h 0", mem[0], wr_count - wc, ref_word(0)); end
      n_cmp++; if (resp_count != rc || req_ready !== 1'b1) begin n_err++; $display("FAIL reset_merge_resp: got resps %0d ready %b want 0 1", resp_count - rc, req_ready); end
      // abort in STORE: the write enable must fall with reset, before any edge
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1; req_wdata = 32'h77;
      idle(1);
      req_valid = 1'b0;
      idle(1);
      n_cmp++; if (mem_write_en !== 1'b1) begin n_err++; $display("FAIL store_wen: got %b want 1", mem_write_en); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (mem_write_en !== 1'b0 || mem_write_data !== 32'd0) begin n_err++; $display("FAIL async_wen_drop: got %b %h want 0 0", mem_write_en, mem_write_data); end
      idle(2);
      reset = 1'b0;
      idle(3);
      n_cmp++; if (wr_count != wc || mem[0] !== ref_word(0) || resp_count != rc) begin n_err++; $display("FAIL reset_store_abort: got %h writes %0d resps %0d want %h 0 0", mem[0], wr_count - wc, resp_count - rc, ref_word(0)); end
   endtask

   task automatic test_hold_valid();
      int wc, rc;
      idle(2);
      wc = wr_count; rc = resp_count;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'hD; req_wdata = 32'h5A;
      idle(1);
      req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hC3C3_C3C3;
      idle(2);
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_resp: got %b want 1", resp_valid); end
      req_valid = 1'b0;
      ref_store(3'd0, 32'hD, 32'h5A);
      idle(3);
      n_cmp++; if (resp_count != rc + 1 || wr_count != wc + 1) begin n_err++; $display("FAIL hold_single: got resps %0d writes %0d want 1 1", resp_count - rc, wr_count - wc); end
      n_cmp++; if (mem[3] !== ref_word(3) || mem[4] !== ref_word(4)) begin n_err++; $display("FAIL hold_mem: got %h %h want %h %h", mem[3], mem[4], ref_word(3), ref_word(4)); end
   endtask

   task automatic test_random();
      logic we; logic [2:0] f3; logic [31:0] a, d, exp_rd, rd; logic exp_ft, ft, to;
      int exp_lat, lat, busy, wc, r;
      for (int n = 0; n < 80; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         r = $urandom_range(0, 9);
         d = $urandom;
         if (r == 0) a = $urandom;
         else a = 32'($urandom_range(0, MEM_BYTES - 1));
         if (r > 0 && r < 7) a = a - (a % size_of(f3));
         exp_ft = ref_fault(we, f3, a);
         exp_rd = (exp_ft || we) ? 32'd0 : ref_load(f3, a);
         exp_lat = (!exp_ft && we && size_of(f3) < 4) ? 2 : 1;
         wc = wr_count;
         do_req(we, f3, a, d, rd, ft, lat, busy, to);
         if (we && !exp_ft) ref_store(f3, a, d);
         n_cmp++;
         if (to || rd !== exp_rd || ft !== exp_ft || lat != exp_lat) begin
            n_err++;
            $display("FAIL rand_%0d we=%b f3=%0d a=%h: got %h/%b/%0d want %h/%b/%0d", n, we, f3, a, rd, ft, lat, exp_rd, exp_ft, exp_lat);
         end
         n_cmp++;
         if (wr_count - wc != ((we && !exp_ft) ? 1 : 0)) begin
            n_err++;
            $display("FAIL rand_writes_%0d: got %0d", n, wr_count - wc);
         end
      end
      for (int i = 0; i < MEM_WORDS; i++) begin
         n_cmp++; if (mem[i] !== ref_word(i)) begin n_err++; $display("FAIL final_mem[%0d]: got %h want %h", i, mem[i], ref_word(i)); end
      end
   endtask

   initial begin
      test_reset();
      test_sub_store();
      test_loads();
      test_faults();
      test_back_to_back();
      test_reset_mid();
      test_hold_valid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
